// File: rtl/erx_deframer_if.sv
// Link-side byte stream in, emesh packet strobe out.
// The link/bench drives the master modport and the deframer sits on the slave modport.
interface erx_deframer_if #(
   parameter int unsigned PW = 104
) ();
   logic          rx_frame;
   logic [7:0]    rx_byte;
   logic          rx_access;
   logic [PW-1:0] rx_packet;
   logic          rx_burst;
   logic [7:0]    err_count;

   modport master (
      output rx_frame,
      output rx_byte,
      input  rx_access,
      input  rx_packet,
      input  rx_burst,
      input  err_count
   );

   modport slave (
      input  rx_frame,
      input  rx_byte,
      output rx_access,
      output rx_packet,
      output rx_burst,
      output err_count
   );
endinterface

// File: rtl/erx_deframer.sv
// Emesh link deframer: assembles byte-serial link frames into 104-bit emesh packets,
// including write bursts whose destination address advances by 8 per beat.
module erx_deframer #(
   parameter int unsigned PW = 104
) (
   input logic          clk,
   input logic          reset,
   erx_deframer_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StCtrl, StAddr, StData, StDrain} state_t;

   state_t        r_state;
   logic [2:0]    r_cnt;
   logic [7:0]    r_ctrl;
   logic [31:0]   r_dst;
   logic [55:0]   r_shift;
   logic          r_cont;
   logic          r_access;
   logic          r_burst;
   logic [PW-1:0] r_packet;
   logic [7:0]    r_err;

   logic [63:0]   w_beat;
   logic          w_burst_wr;
   logic          w_err_sat;
   logic [PW-1:0] w_packet;

   // The byte on the wire this cycle completes the beat, so the packet is built around it.
   assign w_beat     = {r_shift, bus.rx_byte};
   assign w_burst_wr = r_ctrl[1] & r_ctrl[0];
   assign w_err_sat  = (r_err == 8'hFF);
   assign w_packet   = {w_beat[31:0], w_beat[63:32], r_dst,
                        1'b0, r_ctrl[7:4], r_ctrl[3:2], r_ctrl[1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_ctrl   <= '0;
         r_dst    <= '0;
         r_shift  <= '0;
         r_cont   <= 1'b0;
         r_access <= 1'b0;
         r_burst  <= 1'b0;
         r_packet <= '0;
         r_err    <= '0;
      end else begin
         r_access <= 1'b0;
         r_burst  <= 1'b0;
         case (r_state)
            StIdle: begin
               if (bus.rx_frame) begin
                  r_ctrl  <= bus.rx_byte;
                  r_cnt   <= '0;
                  r_cont  <= 1'b0;
                  r_state <= StAddr;
               end
            end

            StAddr: begin
               if (!bus.rx_frame) begin
                  r_state <= StIdle;
                  if (!w_err_sat) r_err <= r_err + 8'd1;
               end else begin
                  r_dst <= {r_dst[23:0], bus.rx_byte};
                  if (r_cnt == 3'd3) begin
                     r_cnt   <= '0;
                     r_state <= StData;
                  end else begin
                     r_cnt <= r_cnt + 3'd1;
                  end
               end
            end

            StData: begin
               if (!bus.rx_frame) begin
                  r_state <= StIdle;
                  if (!w_err_sat) r_err <= r_err + 8'd1;
               end else begin
                  r_shift <= w_beat[55:0];
                  if (r_cnt == 3'd7) begin
                     r_access <= 1'b1;
                     r_burst  <= r_cont;
                     r_packet <= w_packet;
                     r_dst    <= r_dst + 32'd8;
                     r_cnt    <= '0;
                     if (w_burst_wr) begin
                        r_cont  <= 1'b1;
                        r_state <= StCtrl;
                     end else begin
                        r_state <= StDrain;
                     end
                  end else begin
                     r_cnt <= r_cnt + 3'd1;
                  end
               end
            end

            // Burst continuation: this cycle's byte is already data byte 0 of the next beat.
            StCtrl: begin
               if (!bus.rx_frame) begin
                  r_state <= StIdle;
               end else begin
                  r_shift <= w_beat[55:0];
                  r_cnt   <= 3'd1;
                  r_state <= StData;
               end
            end

            StDrain: begin
               if (!bus.rx_frame) r_state <= StIdle;
            end

            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.rx_access = r_access;
   assign bus.rx_packet = r_packet;
   assign bus.rx_burst  = r_burst;
   assign bus.err_count = r_err;

endmodule

// File: tb/tb_erx_deframer.sv
// Bench for erx_deframer: directed frame table, reset/abort corner sequences, and random
// frames checked against a frame-level model of the packet and error rules.
module tb_erx_deframer;
   localparam int unsigned PW = 104;

   typedef struct {
      int            cyc;
      logic [PW-1:0] pkt;
      logic          burst;
   } beat_t;

   typedef struct {
      string         name;
      logic [7:0]    ctrl;
      logic [31:0]   dst;
      logic [31:0]   data;
      logic [31:0]   src;
      int            nbytes;
      int            exp_strobes;
      int            exp_err;
      logic [PW-1:0] exp_pkt;
      logic [31:0]   exp_last_dst;
      logic          exp_last_burst;
   } vec_t;

   logic clk;
   logic reset;

   erx_deframer_if #(.PW(PW)) bus ();

   erx_deframer #(.PW(PW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_tests;
   int            n_fail;
   int            cyc;
   int            viol;
   int            exp_err_total;
   logic          prev_access;
   logic [PW-1:0] prev_pkt;
   logic [7:0]    frm[$];
   beat_t         obs_q[$];
   beat_t         exp_q[$];
   vec_t          vecs[10];

   function automatic int sat(input int x);
      return (x > 255) ? 255 : x;
   endfunction

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, let the edge pass, sample outputs and track invariants.
   task automatic run_cycle(input logic f, input logic [7:0] b);
      bus.rx_frame = f;
      bus.rx_byte  = b;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.rx_access) obs_q.push_back('{cyc, bus.rx_packet, bus.rx_burst});
      if (bus.rx_access && prev_access) viol++;
      if (!bus.rx_access && ((bus.rx_packet !== prev_pkt) || bus.rx_burst)) viol++;
      prev_access = bus.rx_access;
      prev_pkt    = bus.rx_packet;
   endtask

   task automatic send_frame(input int gap);
      foreach (frm[k]) run_cycle(1'b1, frm[k]);
      repeat (gap) run_cycle(1'b0, 8'($urandom));
   endtask

   // Later burst beats carry data+j / src+j so each beat is distinguishable.
   task automatic build_frame(input logic [7:0] ctrl, input logic [31:0] dst,
                              input logic [31:0] data, input logic [31:0] src, input int n);
      logic [31:0] w;
      frm.delete();
      for (int k = 0; k < n; k++) begin
         if (k == 0) frm.push_back(ctrl);
         else if (k < 5) frm.push_back(dst[31-8*(k-1) -: 8]);
         else if (k < 9) frm.push_back(data[31-8*(k-5) -: 8]);
         else if (k < 13) frm.push_back(src[31-8*(k-9) -: 8]);
         else begin
            w = (((k - 13) % 8) < 4) ? data + 32'((k - 13) / 8 + 1) : src + 32'((k - 13) / 8 + 1);
            frm.push_back(w[31-8*((k-13)%4) -: 8]);
         end
      end
   endtask

   // Frame-level reference: beats and aborts follow from the frame length and ctrl byte.
   task automatic model_frame(input int c0);
      int          n;
      int          beats;
      int          off;
      logic [7:0]  ctrl;
      logic [31:0] dst;
      logic [31:0] data;
      logic [31:0] src;
      n = frm.size();
      if (n < 13) begin
         if (n > 0) exp_err_total = sat(exp_err_total + 1);
         return;
      end
      ctrl = frm[0];
      dst  = {frm[1], frm[2], frm[3], frm[4]};
      if (ctrl[1] && ctrl[0]) begin
         beats = 1 + (n - 13) / 8;
         if (((n - 13) % 8) != 0) exp_err_total = sat(exp_err_total + 1);
      end else begin
         beats = 1;
      end
      for (int j = 0; j < beats; j++) begin
         off  = (j == 0) ? 5 : 13 + 8 * (j - 1);
         data = {frm[off], frm[off+1], frm[off+2], frm[off+3]};
         src  = {frm[off+4], frm[off+5], frm[off+6], frm[off+7]};
         exp_q.push_back('{c0 + 1 + off + 7,
                           {src, data, dst + 32'(8 * j), 1'b0, ctrl[7:4], ctrl[3:2], ctrl[1]},
                           (j > 0)});
      end
   endtask

   initial begin
      int            c0;
      int            nmin;
      logic [PW-1:0] p0;

      n_tests = 0; n_fail = 0; cyc = 0; viol = 0; exp_err_total = 0;
      prev_access = 1'b0; prev_pkt = '0;

      vecs[0] = '{"single_write", 8'h02, 32'h80000010, 32'hDEADBEEF, 32'h00000000, 13, 1, 0,
                  {32'h00000000, 32'hDEADBEEF, 32'h80000010, 8'h01}, 32'h80000010, 1'b0};
      vecs[1] = '{"burst3", 8'h03, 32'h00001000, 32'h11223344, 32'h55667788, 29, 3, 0,
                  {32'h55667788, 32'h11223344, 32'h00001000, 8'h01}, 32'h00001010, 1'b1};
      vecs[2] = '{"abort6", 8'h02, 32'h00000001, 32'h00000002, 32'h00000003, 6, 0, 1,
                  104'h0, 32'h0, 1'b0};
      vecs[3] = '{"read_burst", 8'h01, 32'h00002000, 32'hCAFEF00D, 32'h0BADBEEF, 21, 1, 0,
                  {32'h0BADBEEF, 32'hCAFEF00D, 32'h00002000, 8'h00}, 32'h00002000, 1'b0};
      vecs[4] = '{"addr_wrap", 8'h03, 32'hFFFFFFF8, 32'hA5A5A5A5, 32'h5A5A5A5A, 21, 2, 0,
                  {32'h5A5A5A5A, 32'hA5A5A5A5, 32'hFFFFFFF8, 8'h01}, 32'h00000000, 1'b1};
      vecs[5] = '{"ctrl_fields", 8'hAE, 32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 13, 1, 0,
                  {32'h0F1E2D3C, 32'h9ABCDEF0, 32'h12345678, 8'h57}, 32'h12345678, 1'b0};
      vecs[6] = '{"burst_partial", 8'h03, 32'h00000100, 32'h00000001, 32'h00000002, 24, 2, 1,
                  {32'h00000002, 32'h00000001, 32'h00000100, 8'h01}, 32'h00000108, 1'b1};
      vecs[7] = '{"abort12", 8'h02, 32'h00000010, 32'h00000020, 32'h00000030, 12, 0, 1,
                  104'h0, 32'h0, 1'b0};
      vecs[8] = '{"abort1", 8'h02, 32'h0, 32'h0, 32'h0, 1, 0, 1, 104'h0, 32'h0, 1'b0};
      vecs[9] = '{"no_gap", 8'h02, 32'h00000040, 32'h00000007, 32'h00000008, 26, 1, 0,
                  {32'h00000008, 32'h00000007, 32'h00000040, 8'h01}, 32'h00000040, 1'b0};

      // Reset state
      reset = 1'b1; bus.rx_frame = 1'b0; bus.rx_byte = 8'h00;
      #1;
      check("rst_access", PW'(bus.rx_access), PW'(1'b0));
      check("rst_burst", PW'(bus.rx_burst), PW'(1'b0));
      check("rst_packet", bus.rx_packet, '0);
      check("rst_err", PW'(bus.err_count), PW'(8'h00));
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Directed table
      foreach (vecs[i]) begin
         obs_q.delete();
         build_frame(vecs[i].ctrl, vecs[i].dst, vecs[i].data, vecs[i].src, vecs[i].nbytes);
         c0 = cyc;
         send_frame(2);
         exp_err_total = sat(exp_err_total + vecs[i].exp_err);
         check({vecs[i].name, "_strobes"}, PW'(obs_q.size()), PW'(vecs[i].exp_strobes));
         check({vecs[i].name, "_err"}, PW'(bus.err_count), PW'(exp_err_total));
         if (vecs[i].exp_strobes > 0 && obs_q.size() > 0) begin
            check({vecs[i].name, "_pkt"}, obs_q[0].pkt, vecs[i].exp_pkt);
            check({vecs[i].name, "_lat"}, PW'(obs_q[0].cyc), PW'(c0 + 13));
            check({vecs[i].name, "_burst0"}, PW'(obs_q[0].burst), PW'(1'b0));
            check({vecs[i].name, "_last_dst"}, PW'(obs_q[obs_q.size()-1].pkt[39:8]),
                  PW'(vecs[i].exp_last_dst));
            check({vecs[i].name, "_last_burst"}, PW'(obs_q[obs_q.size()-1].burst),
                  PW'(vecs[i].exp_last_burst));
         end
      end

      // Reset at byte 7 of a write, with rx_frame still high across the release
      obs_q.delete();
      build_frame(8'h02, 32'h0000ABCD, 32'h01020304, 32'h05060708, 13);
      for (int k = 0; k < 7; k++) run_cycle(1'b1, frm[k]);
      bus.rx_byte = frm[7];
      reset = 1'b1;
      #1;
      check("midrst_access", PW'(bus.rx_access), PW'(1'b0));
      check("midrst_burst", PW'(bus.rx_burst), PW'(1'b0));
      check("midrst_packet", bus.rx_packet, '0);
      check("midrst_err", PW'(bus.err_count), PW'(8'h00));
      prev_pkt = '0;
      exp_err_total = 0;
      run_cycle(1'b1, frm[8]);
      run_cycle(1'b1, frm[9]);
      reset = 1'b0;
      build_frame(8'h02, 32'h00C0FFEE, 32'h13579BDF, 32'h2468ACE0, 13);
      c0 = cyc;
      send_frame(2);
      check("postrst_strobes", PW'(obs_q.size()), PW'(1));
      if (obs_q.size() > 0) begin
         check("postrst_pkt", obs_q[0].pkt,
               {32'h2468ACE0, 32'h13579BDF, 32'h00C0FFEE, 8'h01});
         check("postrst_lat", PW'(obs_q[0].cyc), PW'(c0 + 13));
      end
      check("postrst_err", PW'(bus.err_count), PW'(8'h00));

      // Random frames against the frame-level model
      for (int f = 0; f < 60; f++) begin
         obs_q.delete();
         exp_q.delete();
         frm.delete();
         for (int k = 0; k < int'($urandom_range(1, 45)); k++) frm.push_back(8'($urandom));
         if ($urandom_range(0, 1) == 1) frm[0][1:0] = 2'b11;
         c0 = cyc;
         model_frame(c0);
         send_frame(int'($urandom_range(1, 3)));
         check($sformatf("rnd%0d_strobes", f), PW'(obs_q.size()), PW'(exp_q.size()));
         nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
         for (int b = 0; b < nmin; b++) begin
            p0 = obs_q[b].pkt;
            check($sformatf("rnd%0d_b%0d_pkt", f, b), p0, exp_q[b].pkt);
            check($sformatf("rnd%0d_b%0d_cyc", f, b), PW'(obs_q[b].cyc), PW'(exp_q[b].cyc));
            check($sformatf("rnd%0d_b%0d_burst", f, b), PW'(obs_q[b].burst),
                  PW'(exp_q[b].burst));
         end
         check($sformatf("rnd%0d_err", f), PW'(bus.err_count), PW'(exp_err_total));
      end

      // 300 aborts saturate the error counter
      obs_q.delete();
      for (int a = 0; a < 300; a++) begin
         build_frame(8'h02, 32'h00000100, 32'h00000200, 32'h00000300, 6);
         send_frame(1);
         exp_err_total = sat(exp_err_total + 1);
      end
      check("sat_err_model", PW'(bus.err_count), PW'(exp_err_total));
      check("sat_err_ff", PW'(bus.err_count), PW'(8'hFF));
      check("sat_strobes", PW'(obs_q.size()), PW'(0));

      check("invariants", PW'(viol), PW'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
